// File: rtl/eq2_bist_checker.sv
// Stimulus/response checker for the 2-bit equality comparator eq2.
// Sweeps all 16 a/b operand pairs, samples aeqb after a settle window,
// counts mismatches (saturating), records the first failing vector and
// reports pass/fail with a one-cycle done pulse.
module eq2_bist_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 5
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             aeqb_i,
    output logic [1:0]       a_o,
    output logic [1:0]       b_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             fail_valid_o,
    output logic [1:0]       fail_a_o,
    output logic [1:0]       fail_b_o
);

    // Settle counter only needs to reach SETTLE_CYCLES-1; keep at least one bit.
    localparam int unsigned     CntW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    state_e           state_q;
    logic [3:0]       idx_q;
    logic [CntW-1:0]  cnt_q;
    logic [1:0]       a_q;
    logic [1:0]       b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;
    logic             fail_valid_q;
    logic [1:0]       fail_a_q;
    logic [1:0]       fail_b_q;

    logic             mismatch;
    logic [3:0]       idx_next;

    // Compare the comparator output against a == b and form the saturating count.
    always_comb begin
        mismatch  = aeqb_i != (a_q == b_q);
        idx_next  = idx_q + 4'd1;
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // Run sequencer with registered stimulus and result outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        idx_q        <= '0;
                        cnt_q        <= '0;
                        err_cnt_q    <= '0;
                        pass_q       <= 1'b0;
                        fail_valid_q <= 1'b0;
                        fail_a_q     <= '0;
                        fail_b_q     <= '0;
                        a_q          <= '0;
                        b_q          <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= StSettle;
                    end
                end
                StSettle: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == SettleLast) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    err_cnt_q <= err_cnt_d;
                    if (mismatch && !fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        fail_a_q     <= a_q;
                        fail_b_q     <= b_q;
                    end
                    if (idx_q == 4'd15) begin
                        a_q     <= '0;
                        b_q     <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // Uses the next count so a mismatch on the last vector is included.
                        pass_q  <= (err_cnt_d == '0);
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_next;
                        a_q     <= idx_next[3:2];
                        b_q     <= idx_next[1:0];
                        cnt_q   <= '0;
                        state_q <= StSettle;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign a_o          = a_q;
    assign b_o          = b_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_cnt_o    = err_cnt_q;
    assign fail_valid_o = fail_valid_q;
    assign fail_a_o     = fail_a_q;
    assign fail_b_o     = fail_b_q;

endmodule
